ex_mem_pipe_ctrl: RTL and testbench

Controls the EX→MEM pipeline boundary for the EX-stage result bundle (inst, pc, ex_result, rw_en, rw_addr, lsu_data, lsu_op).
- Two-entry registered skid buffer with valid/ready handshake on both sides.
- Absorbs MEM-side stalls (LSU busy) without a combinational ready path back into EX.
- Supports pipeline flush.
- Exposes the head entry as a forwarding source for the ID/EX hazard logic.

---
 rtl/ex_mem_pkg.sv | 28 ++
 rtl/pipe_fifo2.sv | 66 ++++++
 rtl/ex_mem_pipe_ctrl.sv | 80 ++++++++
 tb/tb_ex_mem_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX->MEM pipeline boundary.
// Field widths of the bundle are fixed here; the top-level width parameters
// default to these values and must stay consistent with them.
package ex_mem_pkg;

  localparam int EX_INST_W   = 32;
  localparam int EX_ADDR_W   = 32;
  localparam int EX_DATA_W   = 32;
  localparam int EX_REG_W    = 5;
  localparam int EX_LSU_OP_W = 4;

  // Two entries: one at the head being offered to MEM, one to absorb the
  // bundle EX launched while the ready it saw was still high.
  localparam int DEPTH = 2;

  localparam logic [EX_LSU_OP_W-1:0] LSU_OP_NONE = '0;

  typedef struct packed {
    logic [EX_INST_W-1:0]   inst;
    logic [EX_ADDR_W-1:0]   pc;
    logic [EX_DATA_W-1:0]   result;
    logic                   rw_en;
    logic [EX_REG_W-1:0]    rw_addr;
    logic [EX_DATA_W-1:0]   lsu_data;
    logic [EX_LSU_OP_W-1:0] lsu_op;
  } ex_bundle_t;

endpackage

// File: rtl/pipe_fifo2.sv
// Purpose: generic 2-entry circular valid/ready FIFO of ex_bundle_t with synchronous flush.
// Latency: an entry pushed at edge N is presented on out_dat in the cycle after edge N.
// Backpressure: in_rdy = (level != 2), a pure function of state; out_rdy never reaches in_rdy.
// Ports: clk, rst_n (async low), flush; in_vld/in_rdy/in_dat; out_vld/out_rdy/out_dat; level.
module pipe_fifo2
  import ex_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_vld,
  output logic       in_rdy,
  input  ex_bundle_t in_dat,
  output logic       out_vld,
  input  logic       out_rdy,
  output ex_bundle_t out_dat,
  output logic [1:0] level
);

  ex_bundle_t mem_q [DEPTH];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_rdy  = (count != 2'(DEPTH));
  assign out_vld = (count != 2'd0);
  // Slots are zeroed on pop and flush, so an empty FIFO presents all zeros.
  assign out_dat = mem_q[rd_ptr];
  assign level   = count;

  assign push = in_vld & in_rdy & ~flush;
  assign pop  = out_vld & out_rdy & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // push and pop never target the same slot: push needs count<2 and
      // pop needs count>0, so with both active the pointers differ.
      if (push) begin
        mem_q[wr_ptr] <= in_dat;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        mem_q[rd_ptr] <= '0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_pipe_ctrl.sv
// Purpose: EX->MEM boundary register (2-entry skid) plus head-entry forwarding source.
// Latency: bundle accepted at edge N is on mem_* in the cycle after edge N; no comb in->out path.
// Backpressure: ex_ready = occupancy != 2, registered state only; MEM stalls are absorbed by the skid slot.
// Ports: clk, rst_n, flush; ex_* in (valid/ready); mem_* out (valid/ready); fwd_valid/addr/data; occupancy.
module ex_mem_pipe_ctrl
  import ex_mem_pkg::*;
#(
  parameter int INST_W   = EX_INST_W,
  parameter int ADDR_W   = EX_ADDR_W,
  parameter int DATA_W   = EX_DATA_W,
  parameter int REG_W    = EX_REG_W,
  parameter int LSU_OP_W = EX_LSU_OP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [INST_W-1:0]   ex_inst,
  input  logic [ADDR_W-1:0]   ex_pc,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                ex_rw_en,
  input  logic [REG_W-1:0]    ex_rw_addr,
  input  logic [DATA_W-1:0]   ex_lsu_data,
  input  logic [LSU_OP_W-1:0] ex_lsu_op,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [INST_W-1:0]   mem_inst,
  output logic [ADDR_W-1:0]   mem_pc,
  output logic [DATA_W-1:0]   mem_result,
  output logic                mem_rw_en,
  output logic [REG_W-1:0]    mem_rw_addr,
  output logic [DATA_W-1:0]   mem_lsu_data,
  output logic [LSU_OP_W-1:0] mem_lsu_op,
  input  logic                flush,
  output logic                fwd_valid,
  output logic [REG_W-1:0]    fwd_addr,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [1:0]          occupancy
);

  ex_bundle_t in_dat;
  ex_bundle_t head_dat;

  assign in_dat.inst     = ex_inst;
  assign in_dat.pc       = ex_pc;
  assign in_dat.result   = ex_result;
  assign in_dat.rw_en    = ex_rw_en;
  assign in_dat.rw_addr  = ex_rw_addr;
  assign in_dat.lsu_data = ex_lsu_data;
  assign in_dat.lsu_op   = ex_lsu_op;

  pipe_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_vld  (ex_valid),
    .in_rdy  (ex_ready),
    .in_dat  (in_dat),
    .out_vld (mem_valid),
    .out_rdy (mem_ready),
    .out_dat (head_dat),
    .level   (occupancy)
  );

  assign mem_inst     = head_dat.inst;
  assign mem_pc       = head_dat.pc;
  assign mem_result   = head_dat.result;
  assign mem_rw_en    = head_dat.rw_en;
  assign mem_rw_addr  = head_dat.rw_addr;
  assign mem_lsu_data = head_dat.lsu_data;
  assign mem_lsu_op   = head_dat.lsu_op;

  // Only ALU results are known at this point; a load's value arrives from
  // MEM later, and writes to r0 are architecturally discarded.
  assign fwd_valid = mem_valid & head_dat.rw_en & (head_dat.lsu_op == LSU_OP_NONE)
                   & (head_dat.rw_addr != '0);
  assign fwd_addr  = head_dat.rw_addr;
  assign fwd_data  = head_dat.result;

endmodule

// File: tb/tb_ex_mem_pipe_ctrl.sv
module tb_ex_mem_pipe_ctrl;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  ex_bundle_t  ex_b;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_inst, mem_pc, mem_result, mem_lsu_data;
  logic        mem_rw_en;
  logic [4:0]  mem_rw_addr;
  logic [3:0]  mem_lsu_op;
  logic        flush;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;

  ex_bundle_t sb[$];   // expected bundles, in the order MEM must see them
  int         mdl_cnt = 0;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  ex_mem_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_inst(ex_b.inst), .ex_pc(ex_b.pc), .ex_result(ex_b.result),
    .ex_rw_en(ex_b.rw_en), .ex_rw_addr(ex_b.rw_addr),
    .ex_lsu_data(ex_b.lsu_data), .ex_lsu_op(ex_b.lsu_op),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_inst(mem_inst), .mem_pc(mem_pc), .mem_result(mem_result),
    .mem_rw_en(mem_rw_en), .mem_rw_addr(mem_rw_addr),
    .mem_lsu_data(mem_lsu_data), .mem_lsu_op(mem_lsu_op),
    .flush(flush),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ex_bundle_t mk(input logic [31:0] pc, input logic [31:0] res,
                                    input logic rw_en, input logic [4:0] rw_addr,
                                    input logic [3:0] op);
    ex_bundle_t b;
    b.inst     = $urandom;
    b.pc       = pc;
    b.result   = res;
    b.rw_en    = rw_en;
    b.rw_addr  = rw_addr;
    b.lsu_data = $urandom;
    b.lsu_op   = op;
    return b;
  endfunction

  function automatic ex_bundle_t rnd_bundle();
    return mk($urandom, $urandom, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 4'($urandom_range(0, 2)));
  endfunction

  // Drive one cycle of inputs, let the edge happen, and apply the queue
  // model: a 2-deep FIFO where flush empties everything, a pop needs a
  // non-empty queue, and a push needs fewer than two entries beforehand.
  task automatic step(input logic v, input ex_bundle_t b, input logic mr,
                      input logic fl, output bit acc);
    bit do_pop;
    ex_valid  = v;
    ex_b      = b;
    mem_ready = mr;
    flush     = fl;
    @(posedge clk);
    acc = 1'b0;
    if (fl) begin
      sb.delete();
      mdl_cnt = 0;
    end else begin
      do_pop = mr && (mdl_cnt > 0);
      acc    = v && (mdl_cnt < 2);
      if (acc) sb.push_back(b);
      mdl_cnt = mdl_cnt + int'(acc) - int'(do_pop);
    end
    #1;
  endtask

  task automatic idle(input logic mr);
    bit a;
    step(1'b0, '0, mr, 1'b0, a);
  endtask

  // Monitor: every cycle compares the DUT head against the scoreboard and
  // consumes the head whenever MEM takes it at the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      ex_bundle_t act;
      ex_bundle_t h;
      act = '{inst: mem_inst, pc: mem_pc, result: mem_result, rw_en: mem_rw_en,
              rw_addr: mem_rw_addr, lsu_data: mem_lsu_data, lsu_op: mem_lsu_op};
      chk("occupancy", 160'(occupancy), 160'(mdl_cnt));
      chk("ex_ready", 160'(ex_ready), 160'(mdl_cnt != 2));
      chk("mem_valid", 160'(mem_valid), 160'(sb.size() != 0));
      if (sb.size() > 0) begin
        h = sb[0];
        chk("mem_bundle", 160'(act), 160'(h));
        chk("fwd_valid", 160'(fwd_valid),
            160'(h.rw_en && (h.lsu_op == 4'd0) && (h.rw_addr != 5'd0)));
        chk("fwd_addr", 160'(fwd_addr), 160'(h.rw_addr));
        chk("fwd_data", 160'(fwd_data), 160'(h.result));
        if (mem_ready && !flush) void'(sb.pop_front());
      end else begin
        chk("mem_bundle_empty", 160'(act), 160'd0);
        chk("fwd_valid_empty", 160'(fwd_valid), 160'd0);
      end
    end
  end

  initial begin
    bit         a;
    bit         pend;
    ex_bundle_t pb;
    ex_bundle_t b;
    logic       v, mr, fl;

    rst_n = 1'b0; ex_valid = 1'b0; ex_b = '0; mem_ready = 1'b0; flush = 1'b0;
    #12;
    chk("rst_ex_ready", 160'(ex_ready), 160'd1);
    chk("rst_mem_valid", 160'(mem_valid), 160'd0);
    chk("rst_occupancy", 160'(occupancy), 160'd0);
    chk("rst_fwd", 160'({fwd_valid, fwd_addr, fwd_data}), 160'd0);
    chk("rst_mem_pc", 160'(mem_pc), 160'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Back-to-back flow with MEM always ready.
    step(1'b1, mk(32'h1C00_0000, 32'h1, 1'b0, 5'd0, 4'd0), 1'b1, 1'b0, a);
    chk("t1_pc0", 160'(mem_pc), 160'h1C00_0000);
    step(1'b1, mk(32'h1C00_0004, 32'h2, 1'b0, 5'd0, 4'd0), 1'b1, 1'b0, a);
    chk("t1_pc1", 160'(mem_pc), 160'h1C00_0004);
    chk("t1_ready", 160'(ex_ready), 160'd1);
    idle(1'b1);
    chk("t1_drained", 160'(mem_valid), 160'd0);

    // MEM stalled: third bundle must be held by EX until space frees.
    step(1'b1, mk(32'h10, 32'h0, 1'b0, 5'd0, 4'd0), 1'b0, 1'b0, a);
    step(1'b1, mk(32'h14, 32'h0, 1'b0, 5'd0, 4'd0), 1'b0, 1'b0, a);
    chk("t2_full_occ", 160'(occupancy), 160'd2);
    chk("t2_full_rdy", 160'(ex_ready), 160'd0);
    pb = mk(32'h18, 32'h0, 1'b0, 5'd0, 4'd0);
    step(1'b1, pb, 1'b0, 1'b0, a);
    chk("t2_held", 160'(a), 160'd0);
    for (int i = 0; i < 10 && !a; i++) step(1'b1, pb, 1'b1, 1'b0, a);
    chk("t2_accepted", 160'(a), 160'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("t2_empty", 160'(occupancy), 160'd0);

    // Steady state at one entry with simultaneous push and pop.
    step(1'b1, mk(32'h100, 32'h0, 1'b0, 5'd0, 4'd0), 1'b0, 1'b0, a);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, mk(32'h100 + 32'(4 * i), 32'h0, 1'b0, 5'd0, 4'd0), 1'b1, 1'b0, a);
      chk("t3_occ", 160'(occupancy), 160'd1);
      chk("t3_pc", 160'(mem_pc), 160'(32'h100 + 32'(4 * i)));
    end
    idle(1'b1);

    // Flush while full with a new bundle offered.
    step(1'b1, mk(32'h200, 32'h0, 1'b0, 5'd0, 4'd0), 1'b0, 1'b0, a);
    step(1'b1, mk(32'h204, 32'h0, 1'b0, 5'd0, 4'd0), 1'b0, 1'b0, a);
    step(1'b1, mk(32'h208, 32'h0, 1'b0, 5'd0, 4'd0), 1'b1, 1'b1, a);
    chk("t4_valid", 160'(mem_valid), 160'd0);
    chk("t4_occ", 160'(occupancy), 160'd0);
    chk("t4_ready", 160'(ex_ready), 160'd1);
    idle(1'b1);

    // Forwarding qualifiers.
    step(1'b1, mk(32'h300, 32'hDEAD_BEEF, 1'b1, 5'd5, 4'd0), 1'b1, 1'b0, a);
    chk("t5_fwd_v", 160'(fwd_valid), 160'd1);
    chk("t5_fwd_a", 160'(fwd_addr), 160'd5);
    chk("t5_fwd_d", 160'(fwd_data), 160'hDEAD_BEEF);
    step(1'b1, mk(32'h304, 32'hDEAD_BEEF, 1'b1, 5'd5, 4'd2), 1'b1, 1'b0, a);
    chk("t5_load", 160'(fwd_valid), 160'd0);
    step(1'b1, mk(32'h308, 32'hDEAD_BEEF, 1'b1, 5'd0, 4'd0), 1'b1, 1'b0, a);
    chk("t5_r0", 160'(fwd_valid), 160'd0);
    idle(1'b1);

    // Randomized traffic with EX holding any refused bundle.
    pend = 1'b0;
    pb   = '0;
    for (int c = 0; c < 800; c++) begin
      fl = ($urandom_range(0, 24) == 0);
      mr = ($urandom_range(0, 2) != 0);
      if (pend) begin
        v = 1'b1;
        b = pb;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        b = rnd_bundle();
      end
      step(v, b, mr, fl, a);
      pend = v && !a && !fl;
      pb   = b;
    end

    // Asynchronous reset in the middle of a cycle while full.
    step(1'b1, mk(32'h400, 32'h0, 1'b0, 5'd0, 4'd0), 1'b0, 1'b0, a);
    step(1'b1, mk(32'h404, 32'h0, 1'b0, 5'd0, 4'd0), 1'b0, 1'b0, a);
    chk("t6_pre_occ", 160'(occupancy), 160'd2);
    mon_en   = 1'b0;
    ex_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 160'(mem_valid), 160'd0);
    chk("t6_ready", 160'(ex_ready), 160'd1);
    chk("t6_occ", 160'(occupancy), 160'd0);
    chk("t6_pc", 160'(mem_pc), 160'd0);
    sb.delete();
    mdl_cnt = 0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
